tmr_voter_seq: RTL and testbench
================================

# tmr_voter_seq

Registered, parametrised triple-modular-redundancy voter for multi-bit replicated datapaths. It sits after the three copies of a triplicated register or combinational cone, as produced by the triplication pass. Each cycle it emits the bitwise majority of the three replicas, one cycle later. It also tracks which replica disagrees, declares a replica faulty after persistent disagreement, and keeps a saturating error count for system-level health monitoring.

## Interface
Parameters:
- WIDTH, 8: bit width of each replica and of the voted output (≥1).
- PERSIST, 3: consecutive disagreeing valid cycles before a lane is declared faulty (≥1).
- CNT_W, 16: width of the error event counter.

Ports:
- clk  in  1  sole clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  replicas carry a sample this cycle.
- a, b, c  in  WIDTH  replica 0/1/2 data.
- clear  in  1  synchronous clear of lane state, fault flags and err_count.
- out_valid  out  1  out holds a voted sample.
- out  out  WIDTH  bitwise majority of a, b, c.
- err  out  1  at least one lane disagreed with the vote on the sample now on out.
- uncorrectable  out  1  two or more lanes disagreed with the vote on that sample.
- lane_mismatch  out  3  per-lane disagreement on that sample; bit 0 = a.
- fault  out  3  sticky per-lane faulty flag.
- err_count  out  CNT_W  saturating count of samples with err set.

## Operation
- Vote: out_d = (a&b)|(a&c)|(b&c), computed per bit.
- A lane mismatches when its replica differs from out_d in any bit.
- uncorrectable_d is set when popcount(mismatch) ≥ 2. This occurs only when the lanes disagree on different bits. The vote is still emitted.
- Per-lane state machine, updated only on in_valid cycles:
  - LANE_OK: on mismatch, go to LANE_SUSPECT with run=1. If PERSIST==1, go directly to LANE_FAULTY.
  - LANE_SUSPECT: on mismatch, run++. When run reaches PERSIST, go to LANE_FAULTY. On a match, return to LANE_OK with run=0.
  - LANE_FAULTY: sticky; fault[i]=1. Left only through clear or reset.
- err_count increments on every in_valid cycle with any mismatch and saturates at 2^CNT_W−1.
- in_valid low:
  - out_valid=0 next cycle; out holds its last value.
  - err, uncorrectable and lane_mismatch go to 0.
  - Lane state and err_count are unchanged.
- clear:
  - All lanes go to LANE_OK, run=0, fault=0, err_count=0.
  - It overrides any same-cycle update from in_valid, so that sample is not counted.
  - The datapath (out, out_valid, err, uncorrectable, lane_mismatch) is unaffected by clear.
- A faulty lane still takes part in the vote. Exclusion is a system-level decision outside this block.

## Timing
- Latency is 1 cycle. A sample accepted at edge N appears on out/out_valid/err/uncorrectable/lane_mismatch after edge N.
- fault and err_count are registered. They reflect a sample in the same cycle as its out_valid.
- Reset asserted (asynchronous): every output goes to 0 and every lane goes to LANE_OK with run=0.
- Reset mid-stream: in-flight samples are discarded. The first out_valid after release follows the first in_valid that is sampled after release.
- No backpressure: a sample is accepted every cycle in_valid is high.

## Structure
- Package tamara_voter_pkg holds:
  - lane_state_e {LANE_OK, LANE_SUSPECT, LANE_FAULTY};
  - NUM_LANES=3;
  - the lane index constants LANE_A/B/C.
- Sub-module voter_lane_monitor, one instance per lane:
  - inputs: clk, rst_n, valid, mismatch, clear;
  - output: fault;
  - it contains the state machine and a run counter of width $clog2(PERSIST+1).
- The top level holds the majority logic, mismatch detection, output registers and err_count.

## Test plan
- All replicas equal, WIDTH=8, a=b=c=8'hA5, in_valid=1 → next cycle out=8'hA5, out_valid=1, err=0, lane_mismatch=3'b000, err_count stays 0.
- Single-lane upset, b=8'hA4, others 8'hA5 → out=8'hA5, err=1, lane_mismatch=3'b010, uncorrectable=0, err_count=1.
- Multi-lane upset, a=8'h01, b=8'h02, c=8'h00 → out=8'h00, lane_mismatch=3'b011, uncorrectable=1.
- Persistence, PERSIST=3:
  - c wrong for 2 valid cycles, then correct → fault stays 3'b000.
  - c wrong for 3 consecutive valid cycles → fault=3'b100 after the third sample.
  - fault remains 3'b100 after c recovers, until clear; then fault=0 and err_count=0.
- Gaps and saturation:
  - in_valid low between mismatching samples does not break the persistence run; out_valid drops for the gap cycle.
  - CNT_W=4 with 20 mismatching samples → err_count=15.
- Reset and clear corners:
  - rst_n pulsed low mid-stream → all outputs are 0 immediately, before the next clk edge.
  - clear and a mismatching in_valid in the same cycle → err_count=0 and lane state LANE_OK, while out/err still reflect the sample.

Source files
------------

// File: rtl/tmr_voter_seq_pkg.sv
// Shared types and constants for the TMR voter slice.
//   lane_state_e : per-lane health state (OK -> SUSPECT -> FAULTY)
//   NUM_LANES    : replica count (always 3 for TMR)
//   LANE_A/B/C   : bit positions of each replica in per-lane vectors
package tamara_voter_pkg;

  typedef enum logic [1:0] {
    LANE_OK      = 2'd0,
    LANE_SUSPECT = 2'd1,
    LANE_FAULTY  = 2'd2
  } lane_state_e;

  localparam int NUM_LANES = 3;
  localparam int LANE_A    = 0;
  localparam int LANE_B    = 1;
  localparam int LANE_C    = 2;

endpackage

// File: rtl/tmr_voter_seq_if.sv
// Replica/vote bundle between a triplicated datapath and the voter.
//   master : drives in_valid, a, b, c, clear; observes vote and health outputs
//   slave  : the voter; consumes replicas, drives out/out_valid/err/
//            uncorrectable/lane_mismatch/fault/err_count
interface tmr_voter_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  import tamara_voter_pkg::*;

  logic                 in_valid;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     c;
  logic                 clear;
  logic                 out_valid;
  logic [WIDTH-1:0]     out;
  logic                 err;
  logic                 uncorrectable;
  logic [NUM_LANES-1:0] lane_mismatch;
  logic [NUM_LANES-1:0] fault;
  logic [CNT_W-1:0]     err_count;

  modport master (
    output in_valid, a, b, c, clear,
    input  out_valid, out, err, uncorrectable, lane_mismatch, fault, err_count
  );

  modport slave (
    input  in_valid, a, b, c, clear,
    output out_valid, out, err, uncorrectable, lane_mismatch, fault, err_count
  );
endinterface

// File: rtl/tmr_voter_seq_lane_monitor.sv
// Health tracker for one replica lane.
//   clk, rst_n : clock, async active-low reset
//   valid      : a sample is present this cycle; state only moves on these
//   mismatch   : this lane disagreed with the vote on the current sample
//   clear      : synchronous return to LANE_OK, wins over valid
//   fault      : registered sticky faulty flag
module voter_lane_monitor
  import tamara_voter_pkg::*;
#(
  parameter int PERSIST = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic mismatch,
  input  logic clear,
  output logic fault
);

  localparam int RW = $clog2(PERSIST + 1);
  localparam logic [RW-1:0] RUN_ONE  = RW'(1);
  // run value that, with one more mismatch, reaches PERSIST
  localparam logic [RW-1:0] RUN_LAST = RW'(PERSIST - 1);

  lane_state_e   state_q;
  logic [RW-1:0] run_q;
  logic          fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LANE_OK;
      run_q   <= '0;
      fault_q <= 1'b0;
    end else if (clear) begin
      state_q <= LANE_OK;
      run_q   <= '0;
      fault_q <= 1'b0;
    end else if (valid) begin
      unique case (state_q)
        LANE_OK: begin
          if (mismatch) begin
            run_q <= RUN_ONE;
            if (PERSIST == 1) begin
              state_q <= LANE_FAULTY;
              fault_q <= 1'b1;
            end else begin
              state_q <= LANE_SUSPECT;
            end
          end
        end
        LANE_SUSPECT: begin
          if (!mismatch) begin
            state_q <= LANE_OK;
            run_q   <= '0;
          end else if (run_q == RUN_LAST) begin
            state_q <= LANE_FAULTY;
            run_q   <= run_q + RUN_ONE;
            fault_q <= 1'b1;
          end else begin
            run_q <= run_q + RUN_ONE;
          end
        end
        LANE_FAULTY: ;  // sticky until clear/reset
        default: begin
          state_q <= LANE_OK;
          run_q   <= '0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign fault = fault_q;

endmodule

// File: rtl/tmr_voter_seq.sv
// Registered bitwise-majority voter for three replicas with lane health
// tracking and a saturating error-event counter.
//   clk, rst_n : clock, async active-low reset
//   bus        : tmr_voter_seq_if.slave (replicas in, vote + health out)
// The vote lands one cycle after the sample; fault/err_count update on the
// same edge so they line up with the sample's out_valid.
module tmr_voter_seq
  import tamara_voter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PERSIST = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  tmr_voter_seq_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0]     vote_d;
  logic [NUM_LANES-1:0] mism_d;
  logic                 any_d;
  logic                 multi_d;

  logic [WIDTH-1:0]     out_q;
  logic                 out_valid_q;
  logic                 err_q;
  logic                 unc_q;
  logic [NUM_LANES-1:0] lm_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_LANES-1:0] fault_w;

  always_comb begin
    vote_d         = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);
    mism_d         = '0;
    mism_d[LANE_A] = |(bus.a ^ vote_d);
    mism_d[LANE_B] = |(bus.b ^ vote_d);
    mism_d[LANE_C] = |(bus.c ^ vote_d);
    any_d          = |mism_d;
    // two or more lanes off the vote: each disagrees on different bits
    multi_d        = (mism_d[0] & mism_d[1]) | (mism_d[0] & mism_d[2]) |
                     (mism_d[1] & mism_d[2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      unc_q       <= 1'b0;
      lm_q        <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      err_q       <= bus.in_valid & any_d;
      unc_q       <= bus.in_valid & multi_d;
      lm_q        <= bus.in_valid ? mism_d : '0;
      if (bus.in_valid) out_q <= vote_d;
      // clear drops the same-cycle sample from the count
      if (bus.clear)
        cnt_q <= '0;
      else if (bus.in_valid && any_d && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CNT_ONE;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    voter_lane_monitor #(.PERSIST(PERSIST)) u_mon (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (bus.in_valid),
      .mismatch (mism_d[i]),
      .clear    (bus.clear),
      .fault    (fault_w[i])
    );
  end

  assign bus.out           = out_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.err           = err_q;
  assign bus.uncorrectable = unc_q;
  assign bus.lane_mismatch = lm_q;
  assign bus.fault         = fault_w;
  assign bus.err_count     = cnt_q;

endmodule

// File: tb/tb_tmr_voter_seq.sv
module tb_tmr_voter_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmr_voter_seq_if #(.WIDTH(8), .CNT_W(4)) bus ();

  tmr_voter_seq #(.WIDTH(8), .PERSIST(3), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // apply one input vector at negedge, return 1 time unit after posedge
  task automatic step(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [7:0] ic, input logic clr);
    @(negedge clk);
    bus.in_valid = v; bus.a = ia; bus.b = ib; bus.c = ic; bus.clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0; bus.clear = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end checks++;
    if (bus.out !== 8'h00) begin errors++; $display("FAIL rst_out got %h exp 00", bus.out); end checks++;
    if (bus.err !== 1'b0 || bus.uncorrectable !== 1'b0) begin errors++; $display("FAIL rst_err got %b%b exp 00", bus.err, bus.uncorrectable); end checks++;
    if (bus.lane_mismatch !== 3'b000 || bus.fault !== 3'b000) begin errors++; $display("FAIL rst_lanes got %b/%b exp 000/000", bus.lane_mismatch, bus.fault); end checks++;
    if (bus.err_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.err_count); end checks++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_all_equal;
    step(1'b1, 8'hA5, 8'hA5, 8'hA5, 1'b0);
    if (bus.out !== 8'hA5 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL eq_out got %h/%b exp A5/1", bus.out, bus.out_valid); end checks++;
    if (bus.err !== 1'b0 || bus.lane_mismatch !== 3'b000) begin errors++; $display("FAIL eq_err got %b/%b exp 0/000", bus.err, bus.lane_mismatch); end checks++;
    if (bus.err_count !== 4'd0) begin errors++; $display("FAIL eq_count got %0d exp 0", bus.err_count); end checks++;
  endtask

  task automatic test_single_upset;
    step(1'b1, 8'hA5, 8'hA4, 8'hA5, 1'b0);
    if (bus.out !== 8'hA5) begin errors++; $display("FAIL single_out got %h exp A5", bus.out); end checks++;
    if (bus.err !== 1'b1 || bus.uncorrectable !== 1'b0) begin errors++; $display("FAIL single_err got %b/%b exp 1/0", bus.err, bus.uncorrectable); end checks++;
    if (bus.lane_mismatch !== 3'b010) begin errors++; $display("FAIL single_lm got %b exp 010", bus.lane_mismatch); end checks++;
    if (bus.err_count !== 4'd1 || bus.fault !== 3'b000) begin errors++; $display("FAIL single_cnt got %0d/%b exp 1/000", bus.err_count, bus.fault); end checks++;
  endtask

  task automatic test_multi_upset;
    step(1'b1, 8'h01, 8'h02, 8'h00, 1'b0);
    if (bus.out !== 8'h00) begin errors++; $display("FAIL multi_out got %h exp 00", bus.out); end checks++;
    if (bus.lane_mismatch !== 3'b011) begin errors++; $display("FAIL multi_lm got %b exp 011", bus.lane_mismatch); end checks++;
    if (bus.uncorrectable !== 1'b1 || bus.err !== 1'b1) begin errors++; $display("FAIL multi_unc got %b/%b exp 1/1", bus.uncorrectable, bus.err); end checks++;
    if (bus.err_count !== 4'd2) begin errors++; $display("FAIL multi_cnt got %0d exp 2", bus.err_count); end checks++;
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    if (bus.err_count !== 4'd0 || bus.fault !== 3'b000) begin errors++; $display("FAIL multi_clr got %0d/%b exp 0/000", bus.err_count, bus.fault); end checks++;
    if (bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL multi_gap got %b/%b exp 0/0", bus.out_valid, bus.err); end checks++;
  endtask

  task automatic test_persistence;
    step(1'b1, 8'h55, 8'h55, 8'h54, 1'b0);
    step(1'b1, 8'h55, 8'h55, 8'h54, 1'b0);
    step(1'b1, 8'h55, 8'h55, 8'h55, 1'b0);
    if (bus.fault !== 3'b000 || bus.err_count !== 4'd2) begin errors++; $display("FAIL pers_two got %b/%0d exp 000/2", bus.fault, bus.err_count); end checks++;
    step(1'b1, 8'h55, 8'h55, 8'h54, 1'b0);
    step(1'b1, 8'h55, 8'h55, 8'h54, 1'b0);
    if (bus.fault !== 3'b000) begin errors++; $display("FAIL pers_pre got %b exp 000", bus.fault); end checks++;
    step(1'b1, 8'h55, 8'h55, 8'h54, 1'b0);
    if (bus.fault !== 3'b100 || bus.lane_mismatch !== 3'b100) begin errors++; $display("FAIL pers_three got %b/%b exp 100/100", bus.fault, bus.lane_mismatch); end checks++;
    if (bus.err_count !== 4'd5) begin errors++; $display("FAIL pers_cnt got %0d exp 5", bus.err_count); end checks++;
    step(1'b1, 8'h55, 8'h55, 8'h55, 1'b0);
    if (bus.fault !== 3'b100 || bus.err !== 1'b0) begin errors++; $display("FAIL pers_sticky got %b/%b exp 100/0", bus.fault, bus.err); end checks++;
    step(1'b0, 8'h55, 8'h55, 8'h55, 1'b1);
    if (bus.fault !== 3'b000 || bus.err_count !== 4'd0) begin errors++; $display("FAIL pers_clr got %b/%0d exp 000/0", bus.fault, bus.err_count); end checks++;
  endtask

  task automatic test_gap;
    step(1'b1, 8'h11, 8'h11, 8'h10, 1'b0);
    step(1'b0, 8'h77, 8'h77, 8'h77, 1'b0);
    if (bus.out_valid !== 1'b0 || bus.out !== 8'h11) begin errors++; $display("FAIL gap_hold got %b/%h exp 0/11", bus.out_valid, bus.out); end checks++;
    if (bus.err !== 1'b0 || bus.lane_mismatch !== 3'b000 || bus.uncorrectable !== 1'b0) begin errors++; $display("FAIL gap_flags got %b/%b exp 0/000", bus.err, bus.lane_mismatch); end checks++;
    if (bus.err_count !== 4'd1) begin errors++; $display("FAIL gap_cnt got %0d exp 1", bus.err_count); end checks++;
    step(1'b1, 8'h11, 8'h11, 8'h10, 1'b0);
    if (bus.fault !== 3'b000) begin errors++; $display("FAIL gap_pre got %b exp 000", bus.fault); end checks++;
    step(1'b1, 8'h11, 8'h11, 8'h10, 1'b0);
    if (bus.fault !== 3'b100 || bus.err_count !== 4'd3) begin errors++; $display("FAIL gap_fault got %b/%0d exp 100/3", bus.fault, bus.err_count); end checks++;
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 15; i++) step(1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b0);
    if (bus.err_count !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d exp 15", bus.err_count); end checks++;
    for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b0);
    if (bus.err_count !== 4'd15) begin errors++; $display("FAIL sat_20 got %0d exp 15", bus.err_count); end checks++;
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    if (bus.err_count !== 4'd0) begin errors++; $display("FAIL sat_clr got %0d exp 0", bus.err_count); end checks++;
  endtask

  task automatic test_clear_same_cycle;
    step(1'b1, 8'h00, 8'h01, 8'h01, 1'b0);
    if (bus.err_count !== 4'd1) begin errors++; $display("FAIL sc_pre got %0d exp 1", bus.err_count); end checks++;
    step(1'b1, 8'h00, 8'h01, 8'h01, 1'b1);
    if (bus.out !== 8'h01 || bus.err !== 1'b1 || bus.lane_mismatch !== 3'b001) begin errors++; $display("FAIL sc_data got %h/%b/%b exp 01/1/001", bus.out, bus.err, bus.lane_mismatch); end checks++;
    if (bus.err_count !== 4'd0 || bus.fault !== 3'b000) begin errors++; $display("FAIL sc_state got %0d/%b exp 0/000", bus.err_count, bus.fault); end checks++;
    // lane a restarted from LANE_OK: needs three more mismatches to fault
    step(1'b1, 8'h00, 8'h01, 8'h01, 1'b0);
    step(1'b1, 8'h00, 8'h01, 8'h01, 1'b0);
    if (bus.fault !== 3'b000) begin errors++; $display("FAIL sc_run got %b exp 000", bus.fault); end checks++;
    step(1'b1, 8'h00, 8'h01, 8'h01, 1'b0);
    if (bus.fault !== 3'b001 || bus.err_count !== 4'd3) begin errors++; $display("FAIL sc_fault got %b/%0d exp 001/3", bus.fault, bus.err_count); end checks++;
  endtask

  task automatic test_reset_mid;
    step(1'b1, 8'hA5, 8'hA4, 8'hA5, 1'b0);
    if (bus.out_valid !== 1'b1 || bus.err !== 1'b1) begin errors++; $display("FAIL rm_pre got %b/%b exp 1/1", bus.out_valid, bus.err); end checks++;
    #2 rst_n = 1'b0;
    #1;
    if (bus.out_valid !== 1'b0 || bus.out !== 8'h00 || bus.err !== 1'b0) begin errors++; $display("FAIL rm_async got %b/%h/%b exp 0/00/0", bus.out_valid, bus.out, bus.err); end checks++;
    if (bus.fault !== 3'b000 || bus.err_count !== 4'd0 || bus.lane_mismatch !== 3'b000) begin errors++; $display("FAIL rm_state got %b/%0d/%b exp 000/0/000", bus.fault, bus.err_count, bus.lane_mismatch); end checks++;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1; bus.in_valid = 1'b0; bus.clear = 1'b0;
    @(posedge clk); #1;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_idle got %b exp 0", bus.out_valid); end checks++;
    step(1'b1, 8'h3C, 8'h3C, 8'h3C, 1'b0);
    if (bus.out_valid !== 1'b1 || bus.out !== 8'h3C) begin errors++; $display("FAIL rm_first got %b/%h exp 1/3C", bus.out_valid, bus.out); end checks++;
  endtask

  initial begin
    test_reset();
    test_all_equal();
    test_single_upset();
    test_multi_upset();
    test_persistence();
    test_gap();
    test_saturation();
    test_clear_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
